// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch / timer.
// Time is held as six packed BCD digits {mm, ss, cc}.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t [1:0] mm;
    bcd_t [1:0] ss;
    bcd_t [1:0] cc;
  } bcd_time_t;

  localparam int BCD_MAX     = 9;
  localparam int SEC_TEN_MAX = 5;

  function automatic int calc_div(
    input int clk_hz,
    input int tick_hz
  );
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control and display bundle of the stopwatch core.
// The core sits on the slave side.
interface stopwatch_core_if;

  logic        start_stop;
  logic        clear;
  logic        lap;
  logic        mode_down;
  logic [23:0] preset;
  logic [23:0] digits;
  logic        running;
  logic        lap_active;
  logic        done;

  modport master (
    output start_stop,
    output clear,
    output lap,
    output mode_down,
    output preset,
    input  digits,
    input  running,
    input  lap_active,
    input  done
  );

  modport slave (
    input  start_stop,
    input  clear,
    input  lap,
    input  mode_down,
    input  preset,
    output digits,
    output running,
    output lap_active,
    output done
  );

endinterface

// File: rtl/bcd_digit_cnt.sv
// Single BCD decade counter, up or down, with
// synchronous load and a wrap carry/borrow.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int LIMIT = BCD_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dn,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t q,
  output logic cy
);

  localparam bcd_t LIM = bcd_t'(LIMIT);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (dn) begin
        q_d = (q_q == '0) ? LIM : q_q - 1'b1;
      end else begin
        q_d = (q_q == LIM) ? '0 : q_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign cy = en & (dn ? (q_q == '0) : (q_q == LIM));

endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch / count-down timer with run control,
// lap freeze and wrap-or-saturate at the minute limit.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int MAX_MIN = 99,
  parameter int WRAP    = 0
) (
  input  logic clk,
  input  logic rst,
  stopwatch_core_if.slave sw
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam bit WRAP_EN = (WRAP != 0);

  localparam bcd_time_t T_MAX = {
    4'(MAX_MIN / 10), 4'(MAX_MIN % 10),
    4'(SEC_TEN_MAX),  4'(BCD_MAX),
    4'(BCD_MAX),      4'(BCD_MAX)
  };

  sw_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic dn_q, dn_d;
  logic lap_act_q, lap_act_d;
  bcd_time_t lap_q, lap_d;
  logic done_q, done_d;

  bcd_t [5:0] dig;
  bcd_t [5:0] ld_dig;
  logic [5:0] en;
  logic [5:0] cy;
  bcd_time_t cnt;
  bcd_time_t cnt_ld_val;

  logic tick;
  logic term_up;
  logic term_dn;
  logic idle_ld;
  logic cnt_load;
  logic cnt_en;
  logic zero_preset;
  logic unused;

  assign cnt  = bcd_time_t'(dig);
  assign tick = (state_q == RUN) && (presc_q == P_LAST)
              && !sw.clear && !sw.start_stop;

  assign term_up = tick && !dn_q && (cnt == T_MAX);
  assign term_dn = tick && dn_q && (cnt == 24'h000001);

  // Saturation holds the count; wrap reloads zero instead.
  assign cnt_en   = tick && !(term_up && !WRAP_EN);
  assign idle_ld  = sw.clear || (state_q == IDLE);
  assign cnt_load = idle_ld || (term_up && WRAP_EN);

  assign zero_preset = sw.mode_down && (sw.preset == '0);
  assign cnt_ld_val  = (idle_ld && sw.mode_down)
                     ? bcd_time_t'(sw.preset) : '0;
  assign ld_dig = cnt_ld_val;
  assign en     = {cy[4:0], cnt_en};
  assign unused = cy[5];

  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_digit_cnt #(
      .LIMIT((i == 3) ? SEC_TEN_MAX : BCD_MAX)
    ) u_dig (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .dn      (dn_q),
      .load    (cnt_load),
      .load_val(ld_dig[i]),
      .q       (dig[i]),
      .cy      (cy[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (sw.clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sw.start_stop && !zero_preset) state_d = RUN;
        end
        RUN: begin
          if (sw.start_stop) begin
            state_d = PAUSE;
          end else if (term_dn || (term_up && !WRAP_EN)) begin
            state_d = DONE;
          end
        end
        PAUSE: begin
          if (sw.start_stop) state_d = RUN;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  // The pause edge itself does not advance, keeping the fraction.
  always_comb begin
    presc_d = presc_q;
    if (sw.clear || (state_q == IDLE)) begin
      presc_d = '0;
    end else if ((state_q == RUN) && !sw.start_stop) begin
      presc_d = (presc_q == P_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    dn_d      = (state_q == IDLE) ? sw.mode_down : dn_q;
    lap_act_d = lap_act_q;
    lap_d     = lap_q;
    if (sw.clear) begin
      lap_act_d = 1'b0;
    end else if (sw.lap && !sw.start_stop
                 && ((state_q == RUN) || (state_q == PAUSE))) begin
      lap_act_d = !lap_act_q;
      if (!lap_act_q) lap_d = cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      dn_q      <= 1'b0;
      lap_act_q <= 1'b0;
      lap_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dn_q      <= dn_d;
      lap_act_q <= lap_act_d;
      lap_q     <= lap_d;
      done_q    <= done_d;
    end
  end

  assign sw.digits     = lap_act_q ? lap_q : cnt;
  assign sw.running    = (state_q == RUN);
  assign sw.lap_active = lap_act_q;
  assign sw.done       = done_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: main instance at DIV=10 plus
// saturate and wrap instances at DIV=2, MAX_MIN=1.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stopwatch_core_if m();
  stopwatch_core_if s();
  stopwatch_core_if w();

  stopwatch_core #(
    .CLK_HZ(1000), .TICK_HZ(100), .MAX_MIN(99), .WRAP(0)
  ) u_main (.clk(clk), .rst(rst), .sw(m));

  stopwatch_core #(
    .CLK_HZ(200), .TICK_HZ(100), .MAX_MIN(1), .WRAP(0)
  ) u_sat (.clk(clk), .rst(rst), .sw(s));

  stopwatch_core #(
    .CLK_HZ(200), .TICK_HZ(100), .MAX_MIN(1), .WRAP(1)
  ) u_wrp (.clk(clk), .rst(rst), .sw(w));

  // status = {running, lap_active, done, digits}
  localparam logic [2:0] F_IDL = 3'b000;
  localparam logic [2:0] F_RUN = 3'b100;
  localparam logic [2:0] F_LAP = 3'b110;
  localparam logic [2:0] F_DNE = 3'b001;

  typedef struct {
    string       nm;
    logic [26:0] v;
  } sb_t;

  typedef struct {
    string       nm;
    int          tk;
    logic [23:0] d;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  sb_t exp_q[$];
  vec_t tbl[9];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void chk(
    input string nm,
    input logic [26:0] act,
    input logic [26:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endfunction

  function automatic logic [26:0] st_m();
    return {m.running, m.lap_active, m.done, m.digits};
  endfunction

  function automatic logic [26:0] st_s();
    return {s.running, s.lap_active, s.done, s.digits};
  endfunction

  function automatic logic [26:0] st_w();
    return {w.running, w.lap_active, w.done, w.digits};
  endfunction

  task automatic sb_push(input string nm, input logic [26:0] v);
    sb_t e;
    e.nm = nm;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [26:0] act);
    sb_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty got=%h exp=none", act);
    end else begin
      e = exp_q.pop_front();
      chk(e.nm, act, e.v);
    end
  endtask

  task automatic pulse_ss();
    m.start_stop = 1'b1;
    step(1);
    m.start_stop = 1'b0;
  endtask

  task automatic main_seq();
    int cur;
    int cyc;
    int done_cnt;

    tbl[0] = '{"up_1",    1,    24'h000001};
    tbl[1] = '{"up_9",    9,    24'h000009};
    tbl[2] = '{"up_10",   10,   24'h000010};
    tbl[3] = '{"up_99",   99,   24'h000099};
    tbl[4] = '{"up_100",  100,  24'h000100};
    tbl[5] = '{"up_599",  599,  24'h000599};
    tbl[6] = '{"up_1000", 1000, 24'h001000};
    tbl[7] = '{"up_5999", 5999, 24'h005999};
    tbl[8] = '{"up_6000", 6000, 24'h010000};

    // Count k appears on cycle 10k+1 after the start pulse.
    pulse_ss();
    step(9);
    chk("pre_tick", st_m(), {F_RUN, 24'h0});
    cur = 10;
    for (int i = 0; i < 9; i++) begin
      sb_push(tbl[i].nm, {F_RUN, tbl[i].d});
      step(10 * tbl[i].tk + 1 - cur);
      cur = 10 * tbl[i].tk + 1;
      sb_pop(st_m());
    end

    step(4);
    pulse_ss();
    chk("paused", st_m(), {F_IDL, 24'h010000});
    step(25);
    chk("pause_hold_a", st_m(), {F_IDL, 24'h010000});
    step(25);
    chk("pause_hold_b", st_m(), {F_IDL, 24'h010000});
    pulse_ss();
    step(5);
    chk("resume_r6", st_m(), {F_RUN, 24'h010000});
    step(1);
    chk("resume_r7", st_m(), {F_RUN, 24'h010001});

    m.clear = 1'b1;
    m.start_stop = 1'b1;
    step(1);
    m.clear = 1'b0;
    m.start_stop = 1'b0;
    chk("clr_prio", st_m(), {F_IDL, 24'h0});
    step(3);
    chk("clr_stay", st_m(), {F_IDL, 24'h0});

    pulse_ss();
    step(50);
    chk("lap_pre", st_m(), {F_RUN, 24'h000005});
    m.lap = 1'b1;
    step(1);
    m.lap = 1'b0;
    chk("lap_on", st_m(), {F_LAP, 24'h000005});
    step(199);
    chk("lap_hold", st_m(), {F_LAP, 24'h000005});
    m.lap = 1'b1;
    step(1);
    m.lap = 1'b0;
    chk("lap_off", st_m(), {F_RUN, 24'h000025});

    m.mode_down = 1'b1;
    m.preset = 24'h0;
    m.clear = 1'b1;
    step(1);
    m.clear = 1'b0;
    pulse_ss();
    step(3);
    chk("zero_preset", st_m(), {F_IDL, 24'h0});

    m.preset = 24'h000003;
    step(1);
    chk("dn_load", st_m(), {F_IDL, 24'h000003});
    pulse_ss();
    sb_push("dn_2", {F_RUN, 24'h000002});
    sb_push("dn_1", {F_RUN, 24'h000001});
    sb_push("dn_0", {F_DNE, 24'h000000});
    cyc = 1;
    done_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      if (cyc == 11 || cyc == 21 || cyc == 31) sb_pop(st_m());
      if (m.done) done_cnt++;
      step(1);
      cyc++;
    end
    chk("dn_done_once", 27'(done_cnt), 27'd1);
    chk("dn_final", st_m(), {F_IDL, 24'h0});
    pulse_ss();
    step(15);
    chk("done_ign_ss", st_m(), {F_IDL, 24'h0});
    m.lap = 1'b1;
    step(1);
    m.lap = 1'b0;
    chk("done_ign_lap", st_m(), {F_IDL, 24'h0});

    m.mode_down = 1'b0;
    m.clear = 1'b1;
    step(1);
    m.clear = 1'b0;
    pulse_ss();
    step(34);
    chk("rst_pre", st_m(), {F_RUN, 24'h000003});
    #2 rst = 1'b0;
    #1;
    chk("rst_async", st_m(), {F_IDL, 24'h0});
    step(2);
    rst = 1'b1;
    step(1);
    chk("rst_idle", st_m(), {F_IDL, 24'h0});
    pulse_ss();
    step(9);
    chk("rst_restart_a", st_m(), {F_RUN, 24'h0});
    step(1);
    chk("rst_restart_b", st_m(), {F_RUN, 24'h000001});
  endtask

  // DIV=2: count k appears on cycle 2k+1 after the start pulse.
  task automatic limit_seq();
    s.start_stop = 1'b1;
    w.start_stop = 1'b1;
    step(1);
    s.start_stop = 1'b0;
    w.start_stop = 1'b0;
    step(23998);
    chk("sat_pre", st_s(), {F_RUN, 24'h015999});
    chk("wrp_pre", st_w(), {F_RUN, 24'h015999});
    step(1);
    chk("sat_edge", st_s(), {F_RUN, 24'h015999});
    chk("wrp_edge", st_w(), {F_RUN, 24'h015999});
    step(1);
    chk("sat_hold", st_s(), {F_DNE, 24'h015999});
    chk("wrp_zero", st_w(), {F_RUN, 24'h000000});
    step(1);
    chk("sat_end", st_s(), {F_IDL, 24'h015999});
    chk("wrp_run", st_w(), {F_RUN, 24'h000000});
    step(1);
    chk("wrp_next", st_w(), {F_RUN, 24'h000001});
  endtask

  initial begin
    rst = 1'b0;
    m.start_stop = 1'b0;
    m.clear = 1'b0;
    m.lap = 1'b0;
    m.mode_down = 1'b0;
    m.preset = 24'h0;
    s.start_stop = 1'b0;
    s.clear = 1'b0;
    s.lap = 1'b0;
    s.mode_down = 1'b0;
    s.preset = 24'h0;
    w.start_stop = 1'b0;
    w.clear = 1'b0;
    w.lap = 1'b0;
    w.mode_down = 1'b0;
    w.preset = 24'h0;
    step(2);
    chk("reset_main", st_m(), {F_IDL, 24'h0});
    chk("reset_sat", st_s(), {F_IDL, 24'h0});
    rst = 1'b1;
    step(2);
    chk("idle_main", st_m(), {F_IDL, 24'h0});
    fork
      main_seq();
      limit_seq();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised successor to the fixed 10 ms / sec / min stopwatch chain.
- Counts in native BCD: centiseconds, seconds and minutes, so no binary-to-BCD stage is needed downstream.
- Adds run control (start/stop, clear, lap freeze), a count-down timer mode with a preset load, and selectable wrap or saturate at the limit.
- Feeds the existing seg_dynamic-style display driver through a packed 6-digit BCD bus.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, base tick rate in Hz; one tick adds or subtracts 1 centisecond. DIV = CLK_HZ/TICK_HZ, integer, must be >= 2.
- MAX_MIN, 99, highest minute value, 1..99.
- WRAP, 0, up-count limit behaviour: 1 wraps to 00:00.00, 0 saturates and enters DONE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start_stop  in  1  one-cycle pulse; toggles run/pause
- clear  in  1  one-cycle pulse; returns to IDLE and reloads
- lap  in  1  one-cycle pulse; toggles the display freeze
- mode_down  in  1  0 = stopwatch (count up), 1 = timer (count down); sampled only in IDLE
- preset  in  24  BCD {mm,ss,cc} loaded in down mode; all nibbles must be <= 9, ss <= 59, mm <= MAX_MIN
- digits  out  24  BCD {min_ten,min_unit,sec_ten,sec_unit,cs_ten,cs_unit} shown on the display
- running  out  1  high in RUN
- lap_active  out  1  high while digits is frozen
- done  out  1  one-cycle pulse when DONE is entered

Behaviour:
- Reset values: all counters 0, prescaler 0, state IDLE, digits = 0, running = 0, lap_active = 0, done = 0.
- States:
  - IDLE: count = 0 in up mode, count = preset in down mode, reloaded every cycle.
  - RUN: counting.
  - PAUSE: holding.
  - DONE: terminal.
- Transitions:
  - IDLE -start_stop-> RUN.
  - RUN -start_stop-> PAUSE.
  - PAUSE -start_stop-> RUN.
  - RUN -terminal-> DONE.
  - Any state -clear-> IDLE.
  - DONE ignores start_stop and lap.
  - IDLE with a down-mode preset of 00:00.00 ignores start_stop.
- Event priority in the same cycle: clear > start_stop > lap > tick.
- Prescaler:
  - Counts 0..DIV-1 only in RUN; tick is asserted when it equals DIV-1, and the prescaler then wraps to 0.
  - Cleared on IDLE->RUN, so the first tick occurs DIV cycles after the start_stop pulse.
  - Holds its value in PAUSE, preserving the sub-tick fraction.
- Counting: digits update on the cycle after the tick is asserted, i.e. 1 cycle of latency.
  - cs_unit 0-9 carries into cs_ten 0-9, which carries into sec_unit 0-9, then sec_ten 0-5, then minutes 00..MAX_MIN.
  - Down mode borrows symmetrically: 00 reloads 99 (cs) and 59 (sec).
- Terminal conditions:
  - Down mode: on the tick that reaches 00:00.00, enter DONE and pulse done. digits shows 00:00.00.
  - Up mode, WRAP = 0: on the tick that would pass MAX_MIN:59.99, hold MAX_MIN:59.99, enter DONE and pulse done.
  - Up mode, WRAP = 1: next value is 00:00.00; state stays RUN and done is not pulsed.
- Lap:
  - In RUN or PAUSE, lap with lap_active = 0 latches the current count into the display register and sets lap_active.
  - A second lap releases it; digits follows the live count on the next cycle.
  - The counter keeps running underneath while frozen.
  - clear releases the freeze.
- digits equals the lap register when lap_active = 1, otherwise the live count; it is registered.
- Reset asserted mid-run forces the reset values immediately. The first active edge after release behaves as IDLE.

Decomposition:
- Package stopwatch_pkg:
  - sw_state_e enum {IDLE, RUN, PAUSE, DONE}
  - bcd_t (4 bits)
  - bcd_time_t packed struct {mm[2], ss[2], cc[2]}
  - function calc_div(CLK_HZ, TICK_HZ)
  - localparams BCD_MAX = 9 and SEC_TEN_MAX = 5
- One sub-module: bcd_digit_cnt, a single decade counter.
  - Parameter LIMIT.
  - Inputs: en, dn, load, load_val.
  - Outputs: q, plus carry/borrow asserted when en and the count wraps.
  - Six instances are chained; the minute pair is bounded by MAX_MIN in the parent.

Test Plan:
Bench uses CLK_HZ = 1000, TICK_HZ = 100, so DIV = 10.
- Up count: start_stop at cycle 0 -> digits = 00:00.01 on cycle 11. After 100 ticks digits = 00:01.00; after 6000 ticks digits = 01:00.00.
- Pause/resume: pause at prescaler = 4, wait 50 cycles, resume -> the next tick arrives 6 cycles after the resume pulse and digits is unchanged during the pause.
- Down timer: mode_down = 1, preset = 00:00.03, start -> 00:00.02, 00:00.01, 00:00.00 on successive ticks. done pulses exactly once, then DONE; start_stop is ignored.
- Limit handling:
  - MAX_MIN = 1, WRAP = 0: at 01:59.99 the next tick holds the value and pulses done.
  - WRAP = 1: the same tick gives 00:00.00, running stays 1 and done stays 0.
- Lap: lap at 00:00.05 -> digits frozen at 00:00.05 for 20 ticks with lap_active = 1. A second lap shows 00:00.25 on the next cycle.
- Priority and reset: clear + start_stop in the same cycle -> IDLE, digits = 0. Asserting rst low mid-RUN -> all outputs are at their reset values in the same cycle.
